pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter: STALL_CNT_W, default 32, width of the stall counter.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset; synchronous, active-high (1 = reset).
REQ-004 ihit  in  1  instruction fetch complete this cycle.
REQ-005 dhit  in  1  data access complete this cycle.
REQ-006 mem_ren / mem_wen  in  1 each  EX/MEM holds a load / store.
REQ-007 mem_halt  in  1  EX/MEM holds a halt.
REQ-008 pc_redirect  in  1  MEM-stage taken branch, jump or jr.
REQ-009 ex_memread  in  1  ID/EX holds a load.
REQ-010 ex_rd  in  5  ID/EX destination register.
REQ-011 id_rs, id_rt  in  5 each  IF/ID source registers.
REQ-012 id_uses_rt  in  1  IF/ID instruction reads rt.
REQ-013 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch/PC load enables.
REQ-014 ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble at edge; overrides en.
REQ-015 dmemREN, dmemWEN  out  1 each  data request to cache.
REQ-016 dload_capture  out  1  datapath copies dmemload into its hold register.
REQ-017 halt  out  1  registered processor halt.
REQ-018 stall_count  out  STALL_CNT_W  stall-cycle count.

Function
REQ-019 FSM states RUN, DDONE, HALTED; DDONE = data access finished, pipeline not yet advanced.
REQ-020 dmem_ok = !(mem_ren|mem_wen) | dhit | (state==DDONE); advance = ihit & dmem_ok & state!=HALTED.
REQ-021 dmemREN = mem_ren & state==RUN; dmemWEN = mem_wen & state==RUN; both 0 in DDONE, HALTED.
REQ-022 dload_capture = dhit & mem_ren & state==RUN.
REQ-023 RUN->DDONE when (mem_ren|mem_wen) & dhit & !ihit; DDONE->RUN on advance; otherwise hold.
REQ-024 !advance (RUN/DDONE): all en 0, memwb_flush 1, other flushes 0.
REQ-025 Advance, no hazard: all en 1, all flushes 0.
REQ-026 Load-use: ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)); on advance: pc_en 0, ifid_en 0, idex_flush 1, exmem_en 1, memwb_en 1.
REQ-027 pc_redirect on advance: pc_en 1, ifid_flush, idex_flush, exmem_flush 1, memwb_en 1; redirect overrides load-use.
REQ-028 mem_halt on advance: ifid/idex/exmem flush 1, memwb_en 1, pc_en 0, next state HALTED, halt registers 1.
REQ-029 Simultaneous mem_halt and pc_redirect: halt wins.
REQ-030 HALTED: all en 0, all flushes 0, halt held 1 until reset; inputs ignored.
REQ-031 stall_count += 1 each RUN/DDONE cycle with !advance or load-use bubble; saturates at all-ones.
REQ-032 Decisions combinational from current inputs and state; zero added latency.

Reset
REQ-033 nRST=1 at an edge: state RUN, halt 0, stall_count 0; reset mid-access aborts it, no DDONE retained.
REQ-034 While nRST=1: all en 0, all flushes 1, dmemREN/dmemWEN 0, dload_capture 0.

Structure
REQ-035 pctrl_state_t (RUN, DDONE, HALTED) and register-index width constant live in cpu_types_pkg.
REQ-036 One sub-module, hazard_detect: combinational load-use compare per REQ-026.

Verification
REQ-037 Load-use: ex_memread=1, ex_rd=5, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, stall_count 0->1.
REQ-038 $0 hazard: ex_rd=0, id_rs=0 -> no stall, all en 1.
REQ-039 dhit before ihit: mem_ren=1, dhit=1, ihit=0 -> dload_capture=1, state DDONE, dmemREN=0 next cycle; ihit=1 -> advance, state RUN.
REQ-040 Redirect plus load-use same cycle -> pc_en=1, ifid/idex/exmem_flush=1.
REQ-041 mem_halt=1, ihit=1 -> halt=1 next cycle, all en 0 thereafter; nRST=1 -> halt=0, stall_count=0.
REQ-042 Saturation: STALL_CNT_W=4, 20 stall cycles -> stall_count=15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline-controller state encoding and register-index width.
package cpu_types_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DDONE  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources read in IF/ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic                 ex_memread_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic [REG_IDX_W-1:0] id_rs_i,
  input  logic [REG_IDX_W-1:0] id_rt_i,
  input  logic                 id_uses_rt_i,
  output logic                 load_use_o
);

  // Register $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use_o = ex_memread_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller: gates latch enables on memory readiness, hazards, redirects and halt.
module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic                   mem_ren,
  input  logic                   mem_wen,
  input  logic                   mem_halt,
  input  logic                   pc_redirect,
  input  logic                   ex_memread,
  input  logic [REG_IDX_W-1:0]   ex_rd,
  input  logic [REG_IDX_W-1:0]   id_rs,
  input  logic [REG_IDX_W-1:0]   id_rt,
  input  logic                   id_uses_rt,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   memwb_flush,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output logic                   dload_capture,
  output logic                   halt,
  output logic [STALL_CNT_W-1:0] stall_count
);

  pctrl_state_t           state_q, state_d;
  logic                   halt_q, halt_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   load_use, mem_access, dmem_ok, advance, stall_bump;

  hazard_detect u_hazard (
    .ex_memread_i (ex_memread),
    .ex_rd_i      (ex_rd),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .load_use_o   (load_use)
  );

  assign mem_access = mem_ren | mem_wen;
  assign dmem_ok    = !mem_access | dhit | (state_q == DDONE);
  assign advance    = ihit & dmem_ok & (state_q != HALTED);

  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    dmemREN       = mem_ren & (state_q == RUN);
    dmemWEN       = mem_wen & (state_q == RUN);
    dload_capture = dhit & mem_ren & (state_q == RUN);
    state_d       = state_q;
    halt_d        = halt_q;
    stall_bump    = 1'b0;

    // Priority on an advancing cycle: halt, then redirect, then load-use bubble.
    if (state_q != HALTED) begin
      if (!advance) begin
        memwb_flush = 1'b1;
        stall_bump  = 1'b1;
        if ((state_q == RUN) && mem_access && dhit && !ihit) begin
          state_d = DDONE;
        end
      end else if (mem_halt) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
        state_d     = HALTED;
        halt_d      = 1'b1;
      end else if (pc_redirect) begin
        pc_en       = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
        state_d     = RUN;
      end else if (load_use) begin
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        stall_bump = 1'b1;
        state_d    = RUN;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        state_d  = RUN;
      end
    end

    // While reset is held every latch loads a bubble and no memory request leaves.
    if (nRST) begin
      pc_en         = 1'b0;
      ifid_en       = 1'b0;
      idex_en       = 1'b0;
      exmem_en      = 1'b0;
      memwb_en      = 1'b0;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
      memwb_flush   = 1'b1;
      dmemREN       = 1'b0;
      dmemWEN       = 1'b0;
      dload_capture = 1'b0;
    end
  end

  assign stall_d = (stall_bump && (stall_q != '1)) ? stall_q + STALL_CNT_W'(1) : stall_q;

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      stall_q <= stall_d;
    end
  end

  assign halt        = halt_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_pipeline_controller;

  logic       CLK = 1'b0;
  logic       nRST, ihit, dhit, mem_ren, mem_wen, mem_halt, pc_redirect;
  logic       ex_memread, id_uses_rt;
  logic [4:0] ex_rd, id_rs, id_rt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic       dmemREN, dmemWEN, dload_capture, halt;
  logic [3:0] stall_count;

  typedef struct packed {
    logic       rst, ihit, dhit, ren, wen, mhalt, redirect, exMemread;
    logic [4:0] exRd, rs, rt;
    logic       usesRt;
  } stim_t;

  typedef struct packed {
    logic       pcEn, ifidEn, idexEn, exmemEn, memwbEn;
    logic       ifidFlush, idexFlush, exmemFlush, memwbFlush;
    logic       ren, wen, cap, halt;
    logic [3:0] stall;
  } outv_t;

  typedef struct packed {
    outv_t val;
    outv_t mask;
    int    step;
  } expect_t;

  expect_t sb[$];
  int errors = 0;
  int checks = 0;
  int stepNo = 0;

  // Reference model state: halted flag, data-finished-waiting flag, halt output, stall total.
  bit mHalted, mDataDone, mHaltOut;
  int mStall;

  pipeline_controller #(.STALL_CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_halt(mem_halt), .pc_redirect(pc_redirect), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dload_capture(dload_capture), .halt(halt), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  // Drive one cycle of inputs, predict the outputs from the rules, then advance the model.
  task automatic applyStimulus(input stim_t s);
    expect_t e;
    bit memop, go, loadUse;
    @(posedge CLK);
    #1;
    nRST = s.rst; ihit = s.ihit; dhit = s.dhit; mem_ren = s.ren; mem_wen = s.wen;
    mem_halt = s.mhalt; pc_redirect = s.redirect; ex_memread = s.exMemread;
    ex_rd = s.exRd; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.usesRt;

    e.val = '0;
    e.mask = '1;
    e.step = stepNo++;
    e.val.halt = mHaltOut;
    e.val.stall = 4'(mStall);

    if (s.rst) begin
      {e.val.ifidFlush, e.val.idexFlush, e.val.exmemFlush, e.val.memwbFlush} = 4'hF;
      mHalted = 0; mDataDone = 0; mHaltOut = 0; mStall = 0;
    end else if (!mHalted) begin
      memop   = s.ren || s.wen;
      go      = s.ihit && (!memop || s.dhit || mDataDone);
      loadUse = s.exMemread && s.exRd != 0 &&
                (s.exRd == s.rs || (s.usesRt && s.exRd == s.rt));
      e.val.ren = s.ren && !mDataDone;
      e.val.wen = s.wen && !mDataDone;
      e.val.cap = s.dhit && s.ren && !mDataDone;
      if (!go) begin
        e.val.memwbFlush = 1;
        mStall = (mStall < 15) ? mStall + 1 : 15;
        if (memop && s.dhit && !s.ihit) mDataDone = 1;
      end else if (s.mhalt) begin
        {e.val.ifidFlush, e.val.idexFlush, e.val.exmemFlush, e.val.memwbEn} = 4'hF;
        {e.mask.ifidEn, e.mask.idexEn, e.mask.exmemEn} = 3'b000;
        mHalted = 1; mHaltOut = 1; mDataDone = 0;
      end else if (s.redirect) begin
        e.val.pcEn = 1;
        {e.val.ifidFlush, e.val.idexFlush, e.val.exmemFlush, e.val.memwbEn} = 4'hF;
        {e.mask.ifidEn, e.mask.idexEn, e.mask.exmemEn} = 3'b000;
        mDataDone = 0;
      end else if (loadUse) begin
        {e.val.idexFlush, e.val.exmemEn, e.val.memwbEn} = 3'b111;
        e.mask.idexEn = 0;
        mStall = (mStall < 15) ? mStall + 1 : 15;
        mDataDone = 0;
      end else begin
        {e.val.pcEn, e.val.ifidEn, e.val.idexEn, e.val.exmemEn, e.val.memwbEn} = 5'h1F;
        mDataDone = 0;
      end
    end
    sb.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    outv_t act;
    act = '{pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
            exmem_flush, memwb_flush, dmemREN, dmemWEN, dload_capture, halt, stall_count};
    checks++;
    if ((act & e.mask) !== (e.val & e.mask)) begin
      errors++;
      $display("[TB] FAIL outputs step %0d: actual=%b required=%b mask=%b", e.step, act, e.val, e.mask);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    stim_t s;
    nRST = 1; ihit = 0; dhit = 0; mem_ren = 0; mem_wen = 0; mem_halt = 0; pc_redirect = 0;
    ex_memread = 0; ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    mHalted = 0; mDataDone = 0; mHaltOut = 0; mStall = 0;

    s = idle(); s.rst = 1;
    repeat (2) applyStimulus(s);

    // Load-use on r5, then the same compare against $0.
    s = idle(); s.ihit = 1; s.exMemread = 1; s.exRd = 5; s.rs = 5;
    applyStimulus(s);
    s = idle(); s.ihit = 1; s.exMemread = 1;
    applyStimulus(s);

    // Data hit before fetch completes, then fetch completes from DDONE.
    s = idle(); s.ren = 1; s.dhit = 1;
    applyStimulus(s);
    s = idle(); s.ren = 1; s.ihit = 1;
    applyStimulus(s);
    s = idle(); s.ihit = 1;
    applyStimulus(s);

    // Redirect coinciding with a load-use.
    s = idle(); s.ihit = 1; s.redirect = 1; s.exMemread = 1; s.exRd = 7; s.rt = 7; s.usesRt = 1;
    applyStimulus(s);

    // Halt, inputs ignored afterwards, then reset clears it.
    s = idle(); s.ihit = 1; s.mhalt = 1; s.redirect = 1;
    applyStimulus(s);
    s = idle(); s.ihit = 1; s.ren = 1; s.dhit = 1;
    repeat (3) applyStimulus(s);
    s = idle(); s.rst = 1;
    applyStimulus(s);

    // Twenty stall cycles saturate the 4-bit counter.
    s = idle();
    repeat (21) applyStimulus(s);

    s = idle(); s.rst = 1;
    applyStimulus(s);

    for (int i = 0; i < 3000; i++) begin
      s.rst       = ($urandom_range(99) < 2);
      s.ihit      = ($urandom_range(99) < 70);
      s.dhit      = ($urandom_range(99) < 50);
      s.ren       = ($urandom_range(99) < 30);
      s.wen       = !s.ren && ($urandom_range(99) < 25);
      s.mhalt     = ($urandom_range(99) < 3);
      s.redirect  = ($urandom_range(99) < 15);
      s.exMemread = ($urandom_range(99) < 40);
      s.exRd      = 5'($urandom_range(3));
      s.rs        = 5'($urandom_range(3));
      s.rt        = 5'($urandom_range(3));
      s.usesRt    = $urandom_range(1) == 1;
      applyStimulus(s);
    end

    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
